// File: rtl/cei_mochila_obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port among NMASTER requesters.
// An owner FIFO records who was granted so responses return to the right master in order.
module cei_mochila_obi_rr_arbiter #(
   parameter int NMASTER         = 5,
   parameter int MAX_OUTSTANDING = 2,
   parameter int IDX_W           = $clog2(NMASTER)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NMASTER-1:0]     m_req_i,
   input  logic [NMASTER*32-1:0]  m_addr_i,
   input  logic [NMASTER-1:0]     m_we_i,
   input  logic [NMASTER*4-1:0]   m_be_i,
   input  logic [NMASTER*32-1:0]  m_wdata_i,
   output logic [NMASTER-1:0]     m_gnt_o,
   output logic [NMASTER-1:0]     m_rvalid_o,
   output logic [31:0]            m_rdata_o,
   output logic                   s_req_o,
   output logic [31:0]            s_addr_o,
   output logic                   s_we_o,
   output logic [3:0]             s_be_o,
   output logic [31:0]            s_wdata_o,
   input  logic                   s_gnt_i,
   input  logic                   s_rvalid_i,
   input  logic [31:0]            s_rdata_i,
   output logic                   busy_o,
   output logic                   err_o
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [IDX_W-1:0] r_rr_ptr;
   logic [IDX_W-1:0] r_locked_idx;
   logic             r_lock;
   logic             r_err;
   logic [IDX_W-1:0] r_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic [IDX_W-1:0] w_sel;
   logic [IDX_W-1:0] w_head;
   logic             w_found;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_s_req;
   logic             w_accept;
   logic             w_pop;

   function automatic logic [IDX_W-1:0] f_wrap_add(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NMASTER) s = s - NMASTER;
      return IDX_W'(s);
   endfunction

   function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
      return ptr + 1'b1;
   endfunction

   // Scan from rr_ptr; an ungranted request pins the selection until it is accepted.
   always_comb begin
      w_sel   = r_rr_ptr;
      w_found = 1'b0;
      for (int i = 0; i < NMASTER; i++) begin
         if (!w_found && m_req_i[f_wrap_add(r_rr_ptr, i)]) begin
            w_sel   = f_wrap_add(r_rr_ptr, i);
            w_found = 1'b1;
         end
      end
      if (r_lock) w_sel = r_locked_idx;
   end

   assign w_fifo_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_fifo_empty = (r_count == '0);
   assign w_s_req      = m_req_i[w_sel] & ~w_fifo_full & ~rst_i;
   assign w_accept     = w_s_req & s_gnt_i;
   assign w_pop        = s_rvalid_i & ~w_fifo_empty;
   assign w_head       = r_fifo[r_rd_ptr];

   assign s_req_o   = w_s_req;
   assign s_addr_o  = m_addr_i[int'(w_sel)*32 +: 32];
   assign s_we_o    = m_we_i[w_sel];
   assign s_be_o    = m_be_i[int'(w_sel)*4 +: 4];
   assign s_wdata_o = m_wdata_i[int'(w_sel)*32 +: 32];
   assign m_rdata_o = s_rdata_i;
   assign busy_o    = (r_count != '0);
   assign err_o     = r_err;

   always_comb begin
      m_gnt_o            = '0;
      m_gnt_o[w_sel]     = w_accept;
      m_rvalid_o         = '0;
      m_rvalid_o[w_head] = w_pop;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rr_ptr     <= '0;
         r_locked_idx <= '0;
         r_lock       <= 1'b0;
         r_err        <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
      end else begin
         if (w_accept) begin
            r_rr_ptr <= f_wrap_add(w_sel, 1);
            r_lock   <= 1'b0;
            r_wr_ptr <= f_ptr_inc(r_wr_ptr);
         end else if (w_s_req && !s_gnt_i) begin
            r_lock       <= 1'b1;
            r_locked_idx <= w_sel;
         end
         if (w_pop) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A response with nobody waiting for it is a slave protocol error.
         if (s_rvalid_i && w_fifo_empty) r_err <= 1'b1;
      end
   end

   // Owner storage is qualified by the pointers, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (w_accept) r_fifo[r_wr_ptr] <= w_sel;
   end

endmodule

// File: tb/tb_cei_mochila_obi_rr_arbiter.sv
// Directed testbench for cei_mochila_obi_rr_arbiter (NMASTER=5, MAX_OUTSTANDING=2).
module tb_cei_mochila_obi_rr_arbiter;

   localparam int NM = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [NM-1:0]   m_req;
   logic [NM*32-1:0] m_addr;
   logic [NM-1:0]   m_we;
   logic [NM*4-1:0] m_be;
   logic [NM*32-1:0] m_wdata;
   logic [NM-1:0]   m_gnt;
   logic [NM-1:0]   m_rvalid;
   logic [31:0]     m_rdata;
   logic            s_req;
   logic [31:0]     s_addr;
   logic            s_we;
   logic [3:0]      s_be;
   logic [31:0]     s_wdata;
   logic            s_gnt;
   logic            s_rvalid;
   logic [31:0]     s_rdata;
   logic            busy;
   logic            err;

   int n_checks = 0;
   int n_fail   = 0;

   cei_mochila_obi_rr_arbiter #(.NMASTER(NM), .MAX_OUTSTANDING(2)) dut (
      .clk_i(clk), .rst_i(rst),
      .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
      .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
      .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
      .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
      .busy_o(busy), .err_o(err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] addr_of(input int k);
      return 32'h4000_0000 + 32'(k) * 32'h10;
   endfunction

   function automatic logic [31:0] wdata_of(input int k);
      return 32'hD000_0000 + 32'(k);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      m_req    = '0;
      s_gnt    = 1'b0;
      s_rvalid = 1'b0;
      s_rdata  = 32'hA5A5_5A5A;
      m_we     = 5'b01010;
      for (int k = 0; k < NM; k++) begin
         m_addr[32*k +: 32]  = addr_of(k);
         m_wdata[32*k +: 32] = wdata_of(k);
         m_be[4*k +: 4]      = 4'(k + 1);
      end
      step();
      step();
      n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL reset_s_req: got %b expected 0", s_req); end
      n_checks++; if (m_rvalid !== 5'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00000", m_rvalid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
      n_checks++; if (m_rdata !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL reset_rdata_pass: got %h expected a5a55a5a", m_rdata); end
      m_req = 5'b11111;
      s_gnt = 1'b1;
      #1;
      n_checks++; if (s_req !== 1'b0 || m_gnt !== 5'b0) begin n_fail++; $display("FAIL reset_held_req: got s_req=%b gnt=%b expected 0 00000", s_req, m_gnt); end
      m_req = '0;
      s_gnt = 1'b0;
      rst   = 1'b0;
      step();
   endtask

   task automatic test_single();
      m_req = 5'b00100;
      s_gnt = 1'b1;
      #1;
      n_checks++; if (m_gnt !== 5'b00100) begin n_fail++; $display("FAIL single_gnt: got %b expected 00100", m_gnt); end
      n_checks++; if (s_addr !== addr_of(2)) begin n_fail++; $display("FAIL single_addr: got %h expected %h", s_addr, addr_of(2)); end
      n_checks++; if (s_wdata !== wdata_of(2) || s_we !== 1'b0 || s_be !== 4'd3) begin n_fail++; $display("FAIL single_mux: got wdata=%h we=%b be=%h expected %h 0 3", s_wdata, s_we, s_be, wdata_of(2)); end
      step();
      m_req = 5'b11111;
      s_gnt = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
      n_checks++; if (s_addr !== addr_of(3)) begin n_fail++; $display("FAIL single_rr_ptr: got addr %h expected %h", s_addr, addr_of(3)); end
      m_req    = '0;
      s_rvalid = 1'b1;
      s_rdata  = 32'hDEAD_BEEF;
      #1;
      n_checks++; if (m_rvalid !== 5'b00100) begin n_fail++; $display("FAIL single_rvalid: got %b expected 00100", m_rvalid); end
      n_checks++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", m_rdata); end
      step();
      s_rvalid = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [NM-1:0] exp;
      rst = 1'b1;
      #1;
      rst      = 1'b0;
      s_rvalid = 1'b0;
      m_req    = 5'b11111;
      s_gnt    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         exp = 5'b00001 << (i % 5);
         n_checks++; if (m_gnt !== exp) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, m_gnt, exp); end
         if (i > 0) begin
            exp = 5'b00001 << ((i - 1) % 5);
            n_checks++; if (m_rvalid !== exp) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, m_rvalid, exp); end
         end
         step();
         s_rvalid = 1'b1;
      end
      m_req = '0;
      s_gnt = 1'b0;
      #1;
      n_checks++; if (m_rvalid !== 5'b10000) begin n_fail++; $display("FAIL rr_drain: got %b expected 10000", m_rvalid); end
      step();
      s_rvalid = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_lock();
      // Move rr_ptr from 0 to 1 with a single grant to master 0.
      m_req = 5'b00001;
      s_gnt = 1'b1;
      #1;
      n_checks++; if (m_gnt !== 5'b00001) begin n_fail++; $display("FAIL lock_prep_gnt: got %b expected 00001", m_gnt); end
      step();
      m_req    = '0;
      s_gnt    = 1'b0;
      s_rvalid = 1'b1;
      step();
      s_rvalid = 1'b0;
      m_req    = 5'b01010;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (s_addr !== addr_of(1) || s_req !== 1'b1 || m_gnt !== 5'b0) begin n_fail++; $display("FAIL lock_stall[%0d]: got addr=%h req=%b gnt=%b expected %h 1 00000", c, s_addr, s_req, m_gnt, addr_of(1)); end
         step();
      end
      s_gnt = 1'b1;
      #1;
      n_checks++; if (s_addr !== addr_of(1) || m_gnt !== 5'b00010) begin n_fail++; $display("FAIL lock_grant: got addr=%h gnt=%b expected %h 00010", s_addr, m_gnt, addr_of(1)); end
      step();
      m_req    = 5'b10100;
      s_gnt    = 1'b0;
      s_rvalid = 1'b1;
      #1;
      n_checks++; if (s_addr !== addr_of(2)) begin n_fail++; $display("FAIL lock_rr_ptr: got addr %h expected %h", s_addr, addr_of(2)); end
      n_checks++; if (m_rvalid !== 5'b00010) begin n_fail++; $display("FAIL lock_rvalid: got %b expected 00010", m_rvalid); end
      step();
      s_rvalid = 1'b0;
      m_req    = 5'b10000;
      #1;
      n_checks++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL lock_drop: got s_req %b expected 0", s_req); end
      step();
      m_req = 5'b10100;
      s_gnt = 1'b1;
      #1;
      n_checks++; if (m_gnt !== 5'b00100) begin n_fail++; $display("FAIL lock_held: got %b expected 00100", m_gnt); end
      step();
      m_req    = '0;
      s_gnt    = 1'b0;
      s_rvalid = 1'b1;
      #1;
      n_checks++; if (m_rvalid !== 5'b00100) begin n_fail++; $display("FAIL lock_resp: got %b expected 00100", m_rvalid); end
      step();
      s_rvalid = 1'b0;
   endtask

   task automatic test_fifo_full();
      m_req = 5'b01000;
      s_gnt = 1'b1;
      #1;
      n_checks++; if (m_gnt !== 5'b01000) begin n_fail++; $display("FAIL full_gnt0: got %b expected 01000", m_gnt); end
      step();
      m_req = 5'b10000;
      #1;
      n_checks++; if (m_gnt !== 5'b10000) begin n_fail++; $display("FAIL full_gnt1: got %b expected 10000", m_gnt); end
      step();
      m_req = 5'b00001;
      #1;
      n_checks++; if (s_req !== 1'b0 || m_gnt !== 5'b0) begin n_fail++; $display("FAIL full_block: got req=%b gnt=%b expected 0 00000", s_req, m_gnt); end
      s_rvalid = 1'b1;
      #1;
      n_checks++; if (s_req !== 1'b0 || m_rvalid !== 5'b01000) begin n_fail++; $display("FAIL full_pop_same: got req=%b rvalid=%b expected 0 01000", s_req, m_rvalid); end
      step();
      s_rvalid = 1'b0;
      #1;
      n_checks++; if (s_req !== 1'b1 || m_gnt !== 5'b00001) begin n_fail++; $display("FAIL full_release: got req=%b gnt=%b expected 1 00001", s_req, m_gnt); end
      step();
      m_req    = '0;
      s_gnt    = 1'b0;
      s_rvalid = 1'b1;
      #1;
      n_checks++; if (m_rvalid !== 5'b10000) begin n_fail++; $display("FAIL full_resp1: got %b expected 10000", m_rvalid); end
      step();
      n_checks++; if (m_rvalid !== 5'b00001) begin n_fail++; $display("FAIL full_resp2: got %b expected 00001", m_rvalid); end
      step();
      s_rvalid = 1'b0;
   endtask

   task automatic test_owner_routing();
      m_req = 5'b00001;
      s_gnt = 1'b1;
      #1;
      n_checks++; if (m_gnt !== 5'b00001) begin n_fail++; $display("FAIL route_gnt0: got %b expected 00001", m_gnt); end
      step();
      m_req = 5'b10000;
      #1;
      n_checks++; if (m_gnt !== 5'b10000) begin n_fail++; $display("FAIL route_gnt4: got %b expected 10000", m_gnt); end
      step();
      m_req    = '0;
      s_gnt    = 1'b0;
      s_rvalid = 1'b1;
      s_rdata  = 32'h11;
      #1;
      n_checks++; if (m_rvalid !== 5'b00001 || m_rdata !== 32'h11) begin n_fail++; $display("FAIL route_resp0: got %b %h expected 00001 00000011", m_rvalid, m_rdata); end
      step();
      s_rdata = 32'h22;
      #1;
      n_checks++; if (m_rvalid !== 5'b10000 || m_rdata !== 32'h22) begin n_fail++; $display("FAIL route_resp4: got %b %h expected 10000 00000022", m_rvalid, m_rdata); end
      step();
      s_rvalid = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL route_idle: got busy %b expected 0", busy); end
   endtask

   task automatic test_spurious_reset();
      s_rvalid = 1'b1;
      #1;
      n_checks++; if (m_rvalid !== 5'b0 || err !== 1'b0) begin n_fail++; $display("FAIL spur_comb: got rvalid=%b err=%b expected 00000 0", m_rvalid, err); end
      step();
      s_rvalid = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err: got %b expected 1", err); end
      m_req = 5'b00010;
      s_gnt = 1'b1;
      step();
      s_gnt = 1'b0;
      #1;
      n_checks++; if (s_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got req=%b busy=%b expected 1 1", s_req, busy); end
      step();
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_state: got err=%b busy=%b expected 0 0", err, busy); end
      n_checks++; if (s_req !== 1'b0 || m_gnt !== 5'b0) begin n_fail++; $display("FAIL async_rst_req: got req=%b gnt=%b expected 0 00000", s_req, m_gnt); end
      rst   = 1'b0;
      m_req = '0;
      step();
      s_rvalid = 1'b1;
      #1;
      n_checks++; if (m_rvalid !== 5'b0) begin n_fail++; $display("FAIL flight_rvalid: got %b expected 00000", m_rvalid); end
      step();
      s_rvalid = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL flight_err: got %b expected 1", err); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_lock();
      test_fifo_full();
      test_owner_routing();
      test_spurious_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
